// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch state encoding and the opcode
// field layout that both the fetch unit and the PC block decode.
package cpu_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int MSB        = DATA_WIDTH - 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        REQ   = 3'd2,
        VALID = 3'd3,
        ERROR = 3'd4
    } fetch_state_t;

    localparam int SEL_MSB  = 15;
    localparam int SEL_LSB  = 12;
    localparam int OPER_MSB = 11;
    localparam int OPER_LSB = 8;

    // Select values routing an instruction to the PC block.
    localparam logic [3:0] PC_RAM_OP = 4'hE;
    localparam logic [3:0] PC_ROM_OP = 4'hF;
    localparam logic [3:0] PC_OP_JMP = 4'h0;

    function automatic logic [3:0] opcode_select(input logic [MSB:0] op);
        return op[SEL_MSB:SEL_LSB];
    endfunction

    function automatic logic [3:0] opcode_operation(input logic [MSB:0] op);
        return op[OPER_MSB:OPER_LSB];
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// ROM request watchdog: counts request cycles and flags the last allowed one
// so the fetch unit can abandon a ROM that never acknowledges.
module fetch_watchdog #(
    parameter int ROM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    import cpu_pkg::*;

    localparam int CW = $clog2(ROM_TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(ROM_TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Saturates at LAST so a lingering count_en cannot wrap back to zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_en && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: reads the PC, fetches one 32-bit ROM word per instruction
// and hands opcode/operand to the execute stage, advancing the PC on accept.
module instr_fetch_unit #(
    parameter int DATA_WIDTH  = cpu_pkg::DATA_WIDTH,
    parameter int ROM_TIMEOUT = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    halt,
    input  logic [DATA_WIDTH-1:0]   pc,
    output logic                    pc_read_enable,
    output logic                    pc_enable,
    output logic [DATA_WIDTH-1:0]   rom_addr,
    output logic                    rom_req,
    input  logic                    rom_ack,
    input  logic [2*DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0]   opcode,
    output logic [DATA_WIDTH-1:0]   operand,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic                    fetch_error,
    output logic [COUNT_WIDTH-1:0]  retired_count,
    output logic                    busy
);
    import cpu_pkg::*;

    fetch_state_t            r_state;
    fetch_state_t            w_next_state;
    logic [DATA_WIDTH-1:0]   r_rom_addr;
    logic [DATA_WIDTH-1:0]   r_opcode;
    logic [DATA_WIDTH-1:0]   r_operand;
    logic [COUNT_WIDTH-1:0]  r_retired;
    logic                    r_fetch_error;
    logic                    w_capture;
    logic                    w_timeout;
    logic                    w_handshake;
    logic                    w_expired;

    fetch_watchdog #(
        .ROM_TIMEOUT (ROM_TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (r_state == ADDR),
        .count_en (r_state == REQ),
        .expired  (w_expired)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_rom_addr    <= '0;
            r_opcode      <= '0;
            r_operand     <= '0;
            r_retired     <= '0;
            r_fetch_error <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ADDR) begin
                r_rom_addr <= pc;
            end
            if (w_capture) begin
                {r_opcode, r_operand} <= rom_data;
            end
            if (w_handshake) begin
                r_retired <= r_retired + 1'b1;
            end
            if (w_timeout) begin
                r_fetch_error <= 1'b1;
            end
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!halt) begin
                    w_next_state = ADDR;
                end
            end
            ADDR: w_next_state = REQ;
            REQ: begin
                // An ack on the final watchdog cycle still wins.
                if (rom_ack) begin
                    w_capture    = 1'b1;
                    w_next_state = VALID;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_next_state = ERROR;
                end
            end
            VALID: begin
                if (instr_ready) begin
                    w_handshake  = 1'b1;
                    w_next_state = halt ? IDLE : ADDR;
                end
            end
            ERROR:   w_next_state = ERROR;
            default: w_next_state = IDLE;
        endcase
    end

    // Strobes are gated by reset so nothing reaches the PC or ROM while
    // reset is asserted, even before the state register has cleared.
    assign pc_read_enable = reset && (r_state == ADDR);
    assign rom_req        = reset && (r_state == REQ);
    assign instr_valid    = reset && (r_state == VALID);
    assign pc_enable      = reset && w_handshake;

    assign rom_addr       = r_rom_addr;
    assign opcode         = r_opcode;
    assign operand        = r_operand;
    assign fetch_error    = r_fetch_error;
    assign retired_count  = r_retired;
    assign busy           = (r_state != IDLE) && (r_state != ERROR);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural PC block (increment
// or ROM-op jump) and a ROM with programmable acknowledge latency.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    wire  [15:0] pc;
    logic        pc_read_enable;
    logic        pc_enable;
    logic [15:0] rom_addr;
    logic        rom_req;
    logic        rom_ack;
    logic [31:0] rom_data;
    logic [15:0] opcode;
    logic [15:0] operand;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_error;
    logic [15:0] retired_count;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    // PC block model: tri-state read port, jump on a ROM-op JMP.
    logic [15:0] pc_q;
    int          pe_count = 0;
    assign pc = pc_read_enable ? pc_q : 16'hzzzz;

    always @(posedge clk) begin
        if (!reset) begin
            pc_q <= 16'h0;
        end else if (pc_enable) begin
            pe_count <= pe_count + 1;
            if (opcode[15:12] == 4'hF && opcode[11:8] == 4'h0)
                pc_q <= operand;
            else
                pc_q <= pc_q + 16'h1;
        end
    end

    // ROM model: ack after ack_delay request cycles.
    logic [31:0] rom_mem [0:127];
    int          req_cnt = 0;
    int          ack_delay;
    logic        rom_en;
    logic        force_ack;

    assign rom_ack  = force_ack | (rom_en && rom_req && (req_cnt == ack_delay));
    assign rom_data = rom_mem[rom_addr[6:0]];

    always @(posedge clk) begin
        if (rom_req && !rom_ack) req_cnt <= req_cnt + 1;
        else                     req_cnt <= 0;
    end

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .DATA_WIDTH  (16),
        .ROM_TIMEOUT (16),
        .COUNT_WIDTH (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .halt           (halt),
        .pc             (pc),
        .pc_read_enable (pc_read_enable),
        .pc_enable      (pc_enable),
        .rom_addr       (rom_addr),
        .rom_req        (rom_req),
        .rom_ack        (rom_ack),
        .rom_data       (rom_data),
        .opcode         (opcode),
        .operand        (operand),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .fetch_error    (fetch_error),
        .retired_count  (retired_count),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!instr_valid && cycles < 40);
        if (!instr_valid) check({tag, "_valid_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!rom_req && n < 20) begin
            tick();
            n++;
        end
        if (!rom_req) check({tag, "_req_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          cyc;
        int          n;
        int          seen_req;
        int          pe_before;
        logic [15:0] exp_addr [4];

        for (int i = 0; i < 128; i++) rom_mem[i] = 32'h0;
        for (int k = 0; k < 16; k++) rom_mem[k] = {16'h1000 + 16'(k), 16'h00A0 + 16'(k)};

        // Reset with hostile inputs.
        reset = 1'b0; halt = 1'b0; instr_ready = 1'b1;
        force_ack = 1'b1; rom_en = 1'b0; ack_delay = 0;
        #1;
        check("rst_async_strobes", {pc_enable, rom_req, instr_valid, pc_read_enable}, 4'b0);
        repeat (3) tick();
        check("rst_strobes", {pc_enable, rom_req, instr_valid, pc_read_enable}, 4'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", fetch_error, 1'b0);
        check("rst_data", {opcode, operand}, 32'h0);
        check("rst_addr_cnt", {rom_addr, retired_count}, 32'h0);

        force_ack = 1'b0; halt = 1'b1; reset = 1'b1;
        repeat (3) tick();
        check("halt_idle_busy", busy, 1'b0);
        check("halt_idle_pcrd", pc_read_enable, 1'b0);

        // Sequential zero-wait fetch.
        rom_en = 1'b1; ack_delay = 0; halt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_valid("seq", cyc);
            check("seq_gap", cyc, 3);
            check("seq_addr", rom_addr, k);
            check("seq_opcode", opcode, 16'h1000 + 16'(k));
            check("seq_operand", operand, 16'h00A0 + 16'(k));
            check("seq_pc_enable", pc_enable, 1'b1);
            if (k == 3) halt = 1'b1;
        end
        tick();
        check("seq_retired", retired_count, 4);
        check("seq_pc", pc_q, 4);
        check("seq_halt_idle", busy, 1'b0);
        seen_req = 0;
        repeat (4) begin
            tick();
            if (rom_req) seen_req++;
        end
        check("halt_no_req", seen_req, 0);

        // Wait states and backpressure.
        instr_ready = 1'b0; ack_delay = 3; halt = 1'b0;
        pe_before = pe_count;
        wait_req("ws");
        n = 0;
        while (rom_req && n < 20) begin
            check("ws_addr_stable", rom_addr, 16'h4);
            n++;
            tick();
        end
        check("ws_req_cycles", n, 4);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", instr_valid, 1'b1);
            check("bp_opcode_held", opcode, 16'h1004);
            check("bp_no_pc_enable", pc_enable, 1'b0);
            tick();
        end
        instr_ready = 1'b1; halt = 1'b1;
        #1;
        check("bp_pc_enable", pc_enable, 1'b1);
        tick();
        check("bp_pe_after", pc_enable, 1'b0);
        check("bp_pe_pulses", pe_count - pe_before, 1);
        check("bp_pc", pc_q, 5);
        check("bp_retired", retired_count, 5);

        // Jump through the PC block.
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        rom_mem[2]  = {16'hF000, 16'h0040};
        rom_mem[64] = {16'h1040, 16'h00E0};
        exp_addr = '{16'h0, 16'h1, 16'h2, 16'h40};
        ack_delay = 0; instr_ready = 1'b1; halt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_valid("jmp", cyc);
            check("jmp_addr", rom_addr, exp_addr[k]);
            if (k == 3) halt = 1'b1;
        end
        check("jmp_opcode", opcode, 16'h1040);
        tick();
        check("jmp_pc", pc_q, 16'h41);

        // ROM timeout.
        reset = 1'b0;
        tick();
        reset = 1'b1; rom_en = 1'b0; halt = 1'b0;
        wait_req("to");
        n = 0;
        while (!fetch_error && n < 40) begin
            tick();
            n++;
        end
        check("to_cycles", n, 16);
        check("to_req_dropped", rom_req, 1'b0);
        check("to_busy", busy, 1'b0);
        repeat (5) tick();
        check("to_sticky", fetch_error, 1'b1);
        check("to_strobes", {rom_req, pc_read_enable, instr_valid, pc_enable}, 4'b0);
        reset = 1'b0;
        tick();
        check("to_reset_clears", fetch_error, 1'b0);

        // Reset mid-REQ, then a stale ack in IDLE.
        reset = 1'b1; rom_en = 1'b1; ack_delay = 5; halt = 1'b0;
        wait_req("mr");
        tick();
        reset = 1'b0;
        tick();
        check("mr_req_dropped", rom_req, 1'b0);
        check("mr_no_valid", instr_valid, 1'b0);
        halt = 1'b1; reset = 1'b1; force_ack = 1'b1;
        repeat (3) tick();
        check("mr_stale_opcode", opcode, 16'h0);
        check("mr_stale_valid", instr_valid, 1'b0);
        check("mr_idle", busy, 1'b0);
        force_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch sequencer between the program counter block and the instruction ROM.
- Reads the current PC over the PC's tri-state read port and issues a request/acknowledge fetch to a 32-bit-wide ROM.
- Presents opcode/operand to the execute stage with a valid/ready handshake.
- Generates the single-cycle pc_enable that advances the PC once the execute stage accepts the instruction.

Parameters:
DATA_WIDTH, 16, width of pc, opcode, operand, rom_addr
ROM_TIMEOUT, 16, max cycles in REQ without rom_ack before fetch_error (min 2)
COUNT_WIDTH, 16, width of retired_count

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low; reset==0 at a rising edge resets all state
halt  in  1  when 1, no new fetch starts; an in-flight fetch completes
pc  in  DATA_WIDTH  PC value; valid only while pc_read_enable==1
pc_read_enable  out  1  drives the PC block's read_enable
pc_enable  out  1  advance strobe to the PC block
rom_addr  out  DATA_WIDTH  ROM word address
rom_req  out  1  ROM request, level, held until rom_ack
rom_ack  in  1  ROM acknowledge; rom_data valid in the same cycle
rom_data  in  2*DATA_WIDTH  [31:16]=opcode, [15:0]=operand
opcode  out  DATA_WIDTH  registered instruction opcode
operand  out  DATA_WIDTH  registered instruction operand
instr_valid  out  1  opcode/operand valid
instr_ready  in  1  execute stage accepts / has finished the instruction
fetch_error  out  1  sticky ROM timeout flag
retired_count  out  COUNT_WIDTH  instructions accepted since reset
busy  out  1  state != IDLE and state != ERROR

Behaviour:
- Reset values (reset==0): state=IDLE; rom_addr=0; opcode=0; operand=0; retired_count=0; fetch_error=0.
- Under reset, all strobes are 0: rom_req, instr_valid, pc_enable, pc_read_enable.
- Reset overrides every other input in the same cycle.

States: IDLE, ADDR, REQ, VALID, ERROR.

- IDLE:
  - Outputs all low.
  - halt==0 -> ADDR; else stay.
  - rom_ack in IDLE is ignored; this covers a stale ack after mid-fetch reset.
- ADDR (1 cycle):
  - pc_read_enable=1.
  - rom_addr <= pc at the edge.
  - -> REQ.
- REQ:
  - rom_req=1; rom_addr held stable.
  - Watchdog counter cleared on entry, +1 each REQ cycle.
  - rom_ack==1: opcode <= rom_data[31:16], operand <= rom_data[15:0]; -> VALID.
  - Timeout: watchdog reaches ROM_TIMEOUT-1 with rom_ack==0 -> fetch_error <= 1, -> ERROR.
  - rom_ack on the final watchdog cycle wins over timeout.
- VALID:
  - instr_valid=1; opcode/operand held stable.
  - instr_ready==1:
    - pc_enable=1, combinational, same cycle as the handshake, so the PC samples the still-valid opcode/operand at that edge.
    - retired_count += 1, wraps at 2^COUNT_WIDTH.
    - Next state: ADDR if halt==0, else IDLE.
  - instr_ready==0: hold.
- ERROR:
  - Terminal until reset; all strobes 0; fetch_error=1.

PC timing and throughput:
- The PC updates at the pc_enable edge, so ADDR in the following cycle reads the new PC; no extra bubble is needed.
- pc_enable is high only in VALID with instr_ready==1; never more than one pulse per fetched instruction.
- Zero-wait ROM (ack in first REQ cycle): ADDR at cycle n, REQ n+1, instr_valid at n+2.
- Steady-state throughput: one instruction per 3 cycles with instr_ready tied high.
- halt:
  - Sampled in IDLE and at VALID handshake only.
  - Asserting during REQ/VALID does not abort the fetch.
- Reset mid-REQ: rom_req drops in the next cycle; no capture; the ROM must tolerate an abandoned request.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_WIDTH, MSB.
  - Fetch state encoding (IDLE=0, ADDR=1, REQ=2, VALID=3, ERROR=4, 3-bit).
  - Opcode field slices: select [15:12], operation [11:8].
  - PC_RAM_OP/PC_ROM_OP constants, shared with the PC block.
- Sub-module fetch_watchdog:
  - Inputs: clear, count_en.
  - Output: expired at ROM_TIMEOUT-1.
  - Same clk/reset convention.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles with rom_ack=1, instr_ready=1 -> all outputs 0, no pc_enable; release with halt=1 -> stays IDLE, busy=0.
- Sequential fetch, zero-wait ROM:
  - Setup: PC model starts at 0; ROM word k = {16'h1000+k, 16'h00A0+k}; instr_ready=1.
  - rom_addr sequence 0,1,2,3.
  - opcode 16'h1000..16'h1003, operand 16'h00A0..16'h00A3.
  - instr_valid every 3rd cycle; retired_count=4 after 12 cycles.
- Wait states and backpressure:
  - ROM acks 3 cycles after req; instr_ready low for 5 cycles in VALID.
  - rom_addr/rom_req stable until ack; opcode held; exactly one pc_enable when instr_ready rises.
- Jump interaction: ROM word 2 = {16'hF000, 16'h0040} (PC_ROM_OP JMP to 0x40) with the real PC block -> fetch addresses 0,1,2,0x40.
- Timeout: ROM_TIMEOUT=16, rom_ack never asserted -> fetch_error=1 exactly 16 cycles after REQ entry, rom_req=0 thereafter, state ERROR until reset=0.
- Mid-fetch reset and halt:
  - Reset=0 during REQ, then an ack arrives in IDLE -> opcode stays 0, instr_valid=0.
  - halt=1 during VALID with handshake -> returns to IDLE after retiring, no further rom_req.
